// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in prescaled ticks.
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pwm_in       asynchronous PWM input
//   high_cnt     ticks the input was high in the last complete period (R+1 bits)
//   period_cnt   ticks in the last complete period (R+1 bits)
//   meas_valid   one-clk strobe when high_cnt/period_cnt update
//   stuck        no edge seen for 2^(R+1)-1 ticks
//   stuck_level  input level held when stuck asserted
// Optional: define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample majority filter
// after the synchronizer (rejects single-clk glitches, adds one clk of latency).
module pwm_capture #(
    parameter int R           = 8,
    parameter int final_value = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [R:0] high_cnt,
    output logic [R:0] period_cnt,
    output logic       meas_valid,
    output logic       stuck,
    output logic       stuck_level
);
    localparam int W  = R + 1;
    localparam int PW = final_value > 1 ? $clog2(final_value) : 1;
    localparam logic [W-1:0]  MAX  = '1;
    localparam logic [PW-1:0] LAST = PW'(final_value - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [PW-1:0]          pre;
    logic [W-1:0]           hc, pc, hc_inc, pc_inc, ld;
    logic                   s, lvl, lvl_d, rise, fall, tick, armed, timeout;

    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pwm_in};

    assign s = sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge reset)
        if (reset) hist <= '0;
        else       hist <= {hist[0], s};
    assign lvl = (s & hist[0]) | (s & hist[1]) | (hist[0] & hist[1]);
`else
    assign lvl = s;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) lvl_d <= 1'b0;
        else       lvl_d <= lvl;

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    // Free-running prescaler; edges never restart it.
    always_ff @(posedge clk or posedge reset)
        if (reset) pre <= '0;
        else       pre <= tick ? '0 : pre + 1'b1;

    assign tick   = pre == LAST;
    assign hc_inc = hc == MAX ? hc : hc + 1'b1;
    assign pc_inc = pc == MAX ? pc : pc + 1'b1;
    // A tick in the cycle of a rise belongs to the new period.
    assign ld     = {{R{1'b0}}, tick};
    // Edges take priority over a timeout landing in the same cycle.
    assign timeout = tick & (state != IDLE) & (pc == MAX) & ~rise & ~fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hc          <= '0;
            pc          <= '0;
            armed       <= 1'b0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (rise || fall) stuck <= 1'b0;
            if (timeout) begin
                stuck       <= 1'b1;
                stuck_level <= lvl;
                state       <= IDLE;
                armed       <= 1'b0;
                hc          <= '0;
                pc          <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hc <= rise ? ld : '0;
                        pc <= rise ? ld : '0;
                        if (rise)      state <= HIGH;
                        else if (fall) state <= LOW;
                    end
                    LOW: begin
                        if (rise) begin
                            if (armed) begin
                                high_cnt   <= hc;
                                period_cnt <= pc;
                                meas_valid <= 1'b1;
                            end
                            hc    <= ld;
                            pc    <= ld;
                            state <= HIGH;
                        end else if (tick) begin
                            pc <= pc_inc;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= LOW;
                            armed <= 1'b1;
                            if (tick) pc <= pc_inc;
                        end else if (tick) begin
                            hc <= hc_inc;
                            pc <= pc_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture in two configurations (R=8/final_value=4 and R=3/final_value=1).
module tb_pwm_capture;
    logic       clk = 1'b0, reset = 1'b1, pwm0 = 1'b0, pwm1 = 1'b0;
    logic [8:0] hc0, pc0;
    logic [3:0] hc1, pc1;
    logic       mv0, st0, sl0, mv1, st1, sl1;
    int         checks = 0, errors = 0, ncyc = 0, n;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 4;
    localparam bit GF  = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit GF  = 1'b0;
`endif
    // Phase at which a rise lands on a non-tick cycle ending at posedge = 1 mod 4.
    localparam int ALN = (5 - LAT) % 4;

    pwm_capture #(.R(8), .final_value(4), .SYNC_STAGES(2)) u0 (
        .clk(clk), .reset(reset), .pwm_in(pwm0), .high_cnt(hc0), .period_cnt(pc0),
        .meas_valid(mv0), .stuck(st0), .stuck_level(sl0)
    );

    pwm_capture #(.R(3), .final_value(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .reset(reset), .pwm_in(pwm1), .high_cnt(hc1), .period_cnt(pc1),
        .meas_valid(mv1), .stuck(st1), .stuck_level(sl1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input bit d, input int hi, input int lo, input bit ev, input int eh, input int ep);
        if (d) pwm1 = 1'b1; else pwm0 = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (i == 1) chk("stuck_in_run", d ? st1 : st0, 0);
            if (i == LAT - 1) chk("mv_early", d ? mv1 : mv0, 0);
            if (i == LAT) begin
                chk("mv", d ? mv1 : mv0, ev);
                if (ev) begin
                    chk("high_cnt", d ? 32'(hc1) : 32'(hc0), eh);
                    if (ep >= 0) chk("period_cnt", d ? 32'(pc1) : 32'(pc0), ep);
                end
            end
            if (i == LAT + 1) chk("mv_width", d ? mv1 : mv0, 0);
        end
        if (d) pwm1 = 1'b0; else pwm0 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic align();
        for (int g = 0; g < 8 && (ncyc % 4) != ALN; g++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hc0", hc0, 0);
        chk("rst_pc0", pc0, 0);
        chk("rst_mv0", mv0, 0);
        chk("rst_st0", st0, 0);
        chk("rst_sl0", sl0, 0);
        chk("rst_hc1", hc1, 0);
        chk("rst_mv1", mv1, 0);
        chk("rst_st1", st1, 0);
        reset = 1'b0;
        // 40/60 clk waveform: first rise silent, then 10/25 ticks each period
        run(0, 40, 60, 0, 0, 0);
        for (int k = 0; k < 4; k++) run(0, 40, 60, 1, 10, 25);
        // duty 64 of 256 ticks at final_value=4
        run(0, 256, 768, 1, 10, 25);
        run(0, 256, 768, 1, 64, 256);
        run(0, 40, 60, 1, 64, 256);
        // asynchronous reset in the middle of a high phase
        pwm0 = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_reset_hc", hc0, 10);
        chk("pre_reset_pc", pc0, 25);
        #2 reset = 1'b1;
        pwm0 = 1'b0;
        #1;
        chk("async_rst_hc", hc0, 0);
        chk("async_rst_pc", pc0, 0);
        chk("async_rst_mv", mv0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(0, 40, 60, 0, 0, 0);
        chk("post_reset_hc", hc0, 0);
        run(0, 40, 60, 1, 10, 25);
        // rise coincident with a tick: tick counts into the new period
        align();
        run(0, 40, 63, 1, 10, -1);
        run(0, 6, 6, 1, 10, 25);
        run(0, 40, 60, 1, 2, 3);
        // single-clk glitch inside a low phase
        align();
        run(0, 40, 60, 1, 10, -1);
        n = 0;
        pwm0 = 1'b1;
        @(negedge clk);
        if (mv0) n++;
        pwm0 = 1'b0;
        repeat (39) begin
            @(negedge clk);
            if (mv0) n++;
        end
        chk("glitch_mv_count", n, GF ? 0 : 1);
        run(0, 40, 60, 1, GF ? 10 : 0, GF ? 35 : 10);
        // stuck high after one full period (R=3, tick every clk)
        run(1, 5, 5, 0, 0, 0);
        n = 0;
        pwm1 = 1'b1;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(negedge clk);
            if (i == LAT) begin
                chk("b_mv", mv1, 1);
                chk("b_hc", hc1, 5);
                chk("b_pc", pc1, 10);
            end
            if (i == LAT + 14) chk("stuck_early", st1, 0);
            if (i == LAT + 15) begin
                chk("stuck_set", st1, 1);
                chk("stuck_level_hi", sl1, 1);
            end
            if (i > LAT && mv1) n++;
        end
        chk("stuck_no_mv", n, 0);
        chk("stuck_hc_hold", hc1, 5);
        chk("stuck_pc_hold", pc1, 10);
        pwm1 = 1'b0;
        for (int i = 1; i <= LAT + 4; i++) begin
            @(negedge clk);
            if (i == LAT - 1) chk("stuck_before_clear", st1, 1);
            if (i == LAT) begin
                chk("stuck_cleared", st1, 0);
                chk("stuck_level_kept", sl1, 1);
            end
        end
        run(1, 4, 6, 0, 0, 0);
        run(1, 4, 30, 1, 4, 10);
        chk("stuck_low", st1, 1);
        chk("stuck_level_lo", sl1, 0);
        chk("stuck_low_hc", hc1, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
